// File: rtl/encoded_key_decoder_3_to_8.sv
// encoded_key_decoder_3_to_8
//   Receive end of the 8-to-3 priority encoder path in the keypad chain.
//   Synchronises and debounces the encoder outputs, decodes the held key to a
//   registered active-low one-hot bus (74LS138 style) and emits one-cycle
//   press/release strobes for the clock-setting control logic.
// Parameters
//   DELAY          output propagation delay in ns for behavioural models (not applied here)
//   DEBOUNCE       consecutive identical synchronised samples needed to accept (>=1)
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   qc,qb,qa       active-low code from the encoder (qc = MSB)
//   gs             active-low group select; 0 = some key active
//   en_n           active-low output enable, gates y_n only
//   y_n            active-low one-hot decoded key, 8'hFF when no key or disabled
//   key_code       true-binary accepted key, held until the next accept
//   valid          1 while an accepted key is held
//   key_strobe     one-cycle pulse when a press (or a new key) is accepted
//   release_strobe one-cycle pulse when a release is accepted
module encoded_key_decoder_3_to_8 #(
  parameter int DELAY    = 10,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qc,
  input  logic       qb,
  input  logic       qa,
  input  logic       gs,
  input  logic       en_n,
  output logic [7:0] y_n,
  output logic [2:0] key_code,
  output logic       valid,
  output logic       key_strobe,
  output logic       release_strobe
);

  if (DEBOUNCE < 1 || DELAY < 0) begin : g_bad_param
    $error("encoded_key_decoder_3_to_8: DEBOUNCE must be >= 1 and DELAY >= 0");
  end

  localparam int          CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] DB_W = DEBOUNCE[CW:0];

  typedef enum logic [1:0] {
    IDLE,
    QUAL_PRESS,
    PRESSED,
    QUAL_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_cand;
  logic [2:0]      w_cand_nxt;
  logic [2:0]      r_key_code;
  logic            r_valid;
  logic            r_key_strobe;
  logic            r_rel_strobe;

  logic            w_s_gs;
  logic [2:0]      w_s_code;
  logic            w_cnt_done;
  logic            w_go_press;
  logic            w_go_rel;
  logic            w_accept;
  logic            w_release;
  logic [2:0]      w_acc_code;

  assign w_s_gs     = r_sync2[3];
  assign w_s_code   = ~r_sync2[2:0];
  assign w_cnt_done = (({1'b0, r_cnt} + (CW + 1)'(1)) >= DB_W);

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1      <= '1;
      r_sync2      <= '1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cand       <= '0;
      r_key_code   <= '0;
      r_valid      <= 1'b0;
      r_key_strobe <= 1'b0;
      r_rel_strobe <= 1'b0;
    end else begin
      r_sync1      <= {gs, qc, qb, qa};
      r_sync2      <= r_sync1;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cand       <= w_cand_nxt;
      r_key_strobe <= w_accept;
      r_rel_strobe <= w_release;
      if (w_accept) begin
        r_key_code <= w_acc_code;
        r_valid    <= 1'b1;
      end else if (w_release) begin
        r_valid    <= 1'b0;
      end
    end
  end

  // Next-state logic. Entering a qualification phase is funnelled through
  // w_go_press / w_go_rel so that DEBOUNCE=1 accepts on the entry sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_acc_code  = r_cand;
    w_go_press  = 1'b0;
    w_go_rel    = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_s_gs) w_go_press = 1'b1;
      end
      QUAL_PRESS: begin
        if (w_s_gs) begin
          if (r_valid) w_go_rel = 1'b1;
          else         w_state_nxt = IDLE;
        end else if (w_s_code != r_cand) begin
          w_go_press = 1'b1;
        end else if (w_cnt_done) begin
          w_accept    = 1'b1;
          w_acc_code  = r_cand;
          w_state_nxt = PRESSED;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (w_s_gs)                       w_go_rel   = 1'b1;
        else if (w_s_code != r_key_code)  w_go_press = 1'b1;
      end
      QUAL_RELEASE: begin
        if (!w_s_gs) begin
          // A bounce back to the held key is absorbed without any strobe.
          if (w_s_code == r_key_code) w_state_nxt = PRESSED;
          else                        w_go_press  = 1'b1;
        end else if (w_cnt_done) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_go_press) begin
      w_cand_nxt = w_s_code;
      w_cnt_nxt  = CW'(1);
      if (DEBOUNCE == 1) begin
        w_accept    = 1'b1;
        w_acc_code  = w_s_code;
        w_state_nxt = PRESSED;
      end else begin
        w_state_nxt = QUAL_PRESS;
      end
    end

    if (w_go_rel) begin
      w_cnt_nxt = CW'(1);
      if (DEBOUNCE == 1) begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = QUAL_RELEASE;
      end
    end
  end

  // Output decode: combinational gate of registered terms.
  always_comb begin
    y_n = '1;
    if (r_valid && !en_n) y_n = ~(8'b1 << r_key_code);
  end

  assign key_code       = r_key_code;
  assign valid          = r_valid;
  assign key_strobe     = r_key_strobe;
  assign release_strobe = r_rel_strobe;

endmodule
